touch_dir_sequencer: RTL and testbench

Sequencer sitting between the resistive-touch front end and the combinational touch-to-direction decoder. Synchronises and debounces pen-down, latches a coordinate pair into the decoder's hold registers at the right moment, and captures the decoder's 4-bit direction result. Issues each accepted direction to the game logic over a valid/ready handshake, with optional auto-repeat while the pen stays down. Selects map or battle decode mode and freezes it for the duration of a touch.

---
 rtl/touch_pkg.sv | 29 ++
 rtl/touch_db_counter.sv | 52 +++++
 rtl/touch_dir_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_touch_dir_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// touch_pkg: definitions shared by the touch sequencer, its counter and the
// benches around the touch-to-direction decoder.
//   state_t      : sequencer state encoding
//   DIR_*        : one-hot direction codes {right,left,down,up}
//   is_onehot4() : true when exactly one bit of a 4-bit direction is set
package touch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESS_DB    = 3'd1,
    ST_WAIT_SAMPLE = 3'd2,
    ST_LATCH       = 3'd3,
    ST_EMIT        = 3'd4,
    ST_HOLD        = 3'd5,
    ST_RELEASE_DB  = 3'd6
  } state_t;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  // v & (v-1) clears the lowest set bit; zero result plus non-zero input
  // means exactly one bit was set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/touch_db_counter.sv
// touch_db_counter: clear/load/enable counter with a terminal-count flag.
//   DOWN=0 counts up, DOWN=1 counts down and saturates at zero.
//   Priority: clear > load > en.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   clear             force count to zero
//   load, load_val    load count with load_val
//   en                advance count one step
//   tc_val            terminal value to compare against
//   tc                high while count equals tc_val
module touch_db_counter #(
  parameter int W    = 16,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_step;

  generate
    if (DOWN) begin : g_down
      assign count_step = (count_reg == '0) ? count_reg : (count_reg - ONE);
    end else begin : g_up
      assign count_step = count_reg + ONE;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en) begin
      count_reg <= count_step;
    end
  end

  assign tc = (count_reg == tc_val);

endmodule

// File: rtl/touch_dir_sequencer.sv
// touch_dir_sequencer: sits between the resistive-touch front end and the
// combinational direction decoder. Debounces pen-down, latches a coordinate
// pair for the decoder, captures its one-hot result and offers it to the game
// logic over valid/ready. Decode mode is frozen for the whole touch.
// Build option: TOUCH_AUTOREPEAT_EN enables auto-repeat while the pen stays
// down in map mode; without it every touch emits at most once.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   pen_down              raw pen-down (asynchronous, synchronised here)
//   sample_valid          strobe: x_raw/y_raw hold a fresh conversion
//   x_raw, y_raw          raw coordinates
//   battle_en             requested decode mode (1 = battle)
//   dir_in                decoder result for x_hold/y_hold/battle_mode
//   dir_ready             game logic accepts dir_out
//   x_hold, y_hold        latched coordinates to the decoder
//   battle_mode           frozen decode mode to the decoder
//   dir_out, dir_valid    one-hot direction and its valid flag
//   busy                  high outside IDLE
module touch_dir_sequencer
  import touch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int REPEAT_FIRST = 12500000,
  parameter int REPEAT_RATE  = 2500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pen_down,
  input  logic       sample_valid,
  input  logic [7:0] x_raw,
  input  logic [7:0] y_raw,
  input  logic       battle_en,
  input  logic [3:0] dir_in,
  input  logic       dir_ready,
  output logic [7:0] x_hold,
  output logic [7:0] y_hold,
  output logic       battle_mode,
  output logic [3:0] dir_out,
  output logic       dir_valid,
  output logic       busy
);

  localparam int RPT_MAX = (REPEAT_FIRST > REPEAT_RATE) ? REPEAT_FIRST : REPEAT_RATE;
  localparam int CNT_MAX = (DEBOUNCE_CYC > RPT_MAX) ? DEBOUNCE_CYC : RPT_MAX;
  // +1 so a power-of-two parameter value still fits in the counter.
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DEBOUNCE_CYC - 1);

  logic       pen_meta_reg;
  logic       pen_s_reg;

  state_t     state_reg;
  state_t     state_next;

  logic [7:0] x_hold_reg, x_hold_next;
  logic [7:0] y_hold_reg, y_hold_next;
  logic       battle_mode_reg, battle_mode_next;
  logic [3:0] dir_out_reg, dir_out_next;
  logic       dir_valid_reg, dir_valid_next;
  logic       busy_reg, busy_next;

  logic       handshake;
  logic       dir_onehot;
  logic       db_clear;
  logic       db_en;
  logic       db_tc;
  logic       repeat_expire;

  // Two-flop synchroniser for the asynchronous pen-down line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pen_meta_reg <= 1'b0;
      pen_s_reg    <= 1'b0;
    end else begin
      pen_meta_reg <= pen_down;
      pen_s_reg    <= pen_meta_reg;
    end
  end

  assign handshake  = (state_reg == ST_EMIT) && dir_valid_reg && dir_ready;
  assign dir_onehot = is_onehot4(dir_in);

  touch_db_counter #(
    .W    (CNT_W),
    .DOWN (1'b0)
  ) u_db_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (db_clear),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .en       (db_en),
    .tc_val   (DB_TC),
    .tc       (db_tc)
  );

`ifdef TOUCH_AUTOREPEAT_EN
  logic             first_emit_reg;
  logic [CNT_W-1:0] rpt_load_val;
  logic             rpt_load;
  logic             rpt_tc;

  // First emit of a touch waits the long delay; later repeats use the rate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_emit_reg <= 1'b1;
    end else if (state_reg == ST_IDLE) begin
      first_emit_reg <= 1'b1;
    end else if (handshake) begin
      first_emit_reg <= 1'b0;
    end
  end

  assign rpt_load_val = first_emit_reg ? CNT_W'(REPEAT_FIRST) : CNT_W'(REPEAT_RATE);
  // An undecodable sample also arms the timer so a retry is paced rather
  // than re-sampling every few cycles.
  assign rpt_load     = handshake || ((state_reg == ST_LATCH) && !dir_onehot);

  touch_db_counter #(
    .W    (CNT_W),
    .DOWN (1'b1)
  ) u_rpt_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_reg == ST_IDLE),
    .load     (rpt_load),
    .load_val (rpt_load_val),
    .en       (state_reg == ST_HOLD),
    .tc_val   ({CNT_W{1'b0}}),
    .tc       (rpt_tc)
  );

  assign repeat_expire = rpt_tc && !battle_mode_reg;
`else
  assign repeat_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pen_s_reg) state_next = ST_PRESS_DB;
      end
      ST_PRESS_DB: begin
        if (!pen_s_reg)  state_next = ST_IDLE;
        else if (db_tc)  state_next = ST_WAIT_SAMPLE;
      end
      ST_WAIT_SAMPLE: begin
        if (sample_valid)    state_next = ST_LATCH;
        else if (!pen_s_reg) state_next = ST_RELEASE_DB;
      end
      ST_LATCH: begin
        state_next = dir_onehot ? ST_EMIT : ST_HOLD;
      end
      ST_EMIT: begin
        // Pen release is deliberately not looked at until the handshake.
        if (handshake) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!pen_s_reg)         state_next = ST_RELEASE_DB;
        else if (repeat_expire) state_next = ST_WAIT_SAMPLE;
      end
      ST_RELEASE_DB: begin
        if (!pen_s_reg && db_tc) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next-value logic.
  always_comb begin
    x_hold_next      = x_hold_reg;
    y_hold_next      = y_hold_reg;
    battle_mode_next = battle_mode_reg;
    dir_out_next     = dir_out_reg;
    dir_valid_next   = dir_valid_reg;
    busy_next        = (state_next != ST_IDLE);
    db_clear         = 1'b0;
    db_en            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        battle_mode_next = battle_en;
        db_clear         = 1'b1;
      end
      ST_PRESS_DB: begin
        db_en = pen_s_reg;
      end
      ST_WAIT_SAMPLE: begin
        if (sample_valid) begin
          x_hold_next = x_raw;
          y_hold_next = y_raw;
        end
      end
      ST_LATCH: begin
        if (dir_onehot) begin
          dir_out_next   = dir_in;
          dir_valid_next = 1'b1;
        end
      end
      ST_EMIT: begin
        if (handshake) dir_valid_next = 1'b0;
      end
      ST_RELEASE_DB: begin
        // A bounce back to pen-down restarts the stable-low count.
        if (pen_s_reg) db_clear = 1'b1;
        else           db_en    = 1'b1;
      end
      default: ;
    endcase
    // Each debounce phase starts counting from zero.
    if ((state_next != state_reg) &&
        ((state_next == ST_PRESS_DB) || (state_next == ST_RELEASE_DB))) begin
      db_clear = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_hold_reg      <= 8'd0;
      y_hold_reg      <= 8'd0;
      battle_mode_reg <= 1'b0;
      dir_out_reg     <= 4'd0;
      dir_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      x_hold_reg      <= x_hold_next;
      y_hold_reg      <= y_hold_next;
      battle_mode_reg <= battle_mode_next;
      dir_out_reg     <= dir_out_next;
      dir_valid_reg   <= dir_valid_next;
      busy_reg        <= busy_next;
    end
  end

  assign x_hold      = x_hold_reg;
  assign y_hold      = y_hold_reg;
  assign battle_mode = battle_mode_reg;
  assign dir_out     = dir_out_reg;
  assign dir_valid   = dir_valid_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_touch_dir_sequencer.sv
// Bench for touch_dir_sequencer: directed steps in one initial block, with a
// scoreboard of expected directions popped by a handshake monitor.
module tb_touch_dir_sequencer;
  import touch_pkg::*;

  localparam int DB  = 4;
  localparam int RF  = 20;
  localparam int RR  = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pen_down;
  logic       sample_valid;
  logic [7:0] x_raw, y_raw;
  logic       battle_en;
  logic [3:0] dir_in;
  logic       dir_ready;
  logic [7:0] x_hold, y_hold;
  logic       battle_mode;
  logic [3:0] dir_out;
  logic       dir_valid;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int emit_cnt = 0;
  int base;
  int hs0;
  logic [3:0] exp_q[$];
  int         hs_cyc[$];

  touch_dir_sequencer #(
    .DEBOUNCE_CYC (DB),
    .REPEAT_FIRST (RF),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pen_down     (pen_down),
    .sample_valid (sample_valid),
    .x_raw        (x_raw),
    .y_raw        (y_raw),
    .battle_en    (battle_en),
    .dir_in       (dir_in),
    .dir_ready    (dir_ready),
    .x_hold       (x_hold),
    .y_hold       (y_hold),
    .battle_mode  (battle_mode),
    .dir_out      (dir_out),
    .dir_valid    (dir_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Handshake monitor: valid&&ready seen between edges completes at the next edge.
  always @(negedge clk) begin
    if (reset_n && dir_valid && dir_ready) begin
      emit_cnt++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_emit", 32'(exp_q.size()), 32'd1);
      end else begin
        check("emit_dir", 32'(dir_out), 32'(exp_q.pop_front()));
      end
      $display("[TB] emit cyc=%0d dir=%b", cyc, dir_out);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_and_sample(input logic [7:0] x, input logic [7:0] y);
    pen_down = 1'b1;
    tick(10);
    x_raw = x;
    y_raw = y;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (dir_valid) break;
      @(negedge clk);
    end
    check(tag, 32'(dir_valid), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; pen_down = 1'b0; sample_valid = 1'b0;
    x_raw = 8'd0; y_raw = 8'd0; battle_en = 1'b0;
    dir_in = 4'd0; dir_ready = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_x_hold", 32'(x_hold), 32'd0);
    check("rst_y_hold", 32'(y_hold), 32'd0);
    check("rst_battle", 32'(battle_mode), 32'd0);
    check("rst_dir_out", 32'(dir_out), 32'd0);
    check("rst_valid", 32'(dir_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Basic press, map mode, right.
    dir_in = DIR_RIGHT;
    exp_q.push_back(DIR_RIGHT);
    press_and_sample(8'd100, 8'd30);
    @(negedge clk);
    check("t1_x_hold", 32'(x_hold), 32'd100);
    check("t1_y_hold", 32'(y_hold), 32'd30);
    check("t1_valid_edge1", 32'(dir_valid), 32'd0);
    tick(1);
    @(negedge clk);
    check("t1_valid_edge2", 32'(dir_valid), 32'd1);
    check("t1_dir_out", 32'(dir_out), 32'(DIR_RIGHT));
    tick(1);
    @(negedge clk);
    check("t1_valid_drop", 32'(dir_valid), 32'd0);
    tick(5);
    check("t1_single_pulse", 32'(emit_cnt), 32'd1);
    pen_down = 1'b0;
    wait_idle("t1_idle");

    // Pen glitch of 3 cycles with a sample strobe that must be ignored.
    x_raw = 8'd55; y_raw = 8'd77; sample_valid = 1'b1;
    pen_down = 1'b1;
    tick(3);
    pen_down = 1'b0;
    tick(1);
    @(negedge clk);
    check("t2_busy_in_press", 32'(busy), 32'd1);
    tick(8);
    sample_valid = 1'b0;
    check("t2_back_idle", 32'(busy), 32'd0);
    check("t2_x_kept", 32'(x_hold), 32'd100);
    check("t2_y_kept", 32'(y_hold), 32'd30);
    check("t2_no_emit", 32'(emit_cnt), 32'd1);

    // Back-pressure while the pen is released, then release debounce.
    dir_ready = 1'b0;
    dir_in = DIR_UP;
    exp_q.push_back(DIR_UP);
    press_and_sample(8'd10, 8'd200);
    wait_valid("t3_valid_rise");
    pen_down = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      @(negedge clk);
      check("t3_valid_stable", 32'(dir_valid), 32'd1);
      check("t3_dir_stable", 32'(dir_out), 32'(DIR_UP));
    end
    dir_ready = 1'b1;
    tick(1);
    @(negedge clk);
    check("t3_hold", 32'(dut.state_reg), 32'(ST_HOLD));
    check("t3_valid_low", 32'(dir_valid), 32'd0);
    tick(1);
    @(negedge clk);
    check("t3_release_db", 32'(dut.state_reg), 32'(ST_RELEASE_DB));
    tick(3);
    @(negedge clk);
    check("t3_busy_db", 32'(busy), 32'd1);
    tick(1);
    @(negedge clk);
    check("t3_idle", 32'(busy), 32'd0);

    // Auto-repeat in map mode with the pen held.
    battle_en = 1'b0; dir_in = DIR_LEFT; dir_ready = 1'b1;
    x_raw = 8'd5; y_raw = 8'd120; sample_valid = 1'b1;
    base = emit_cnt;
    hs0 = hs_cyc.size();
    pen_down = 1'b1;
`ifdef TOUCH_AUTOREPEAT_EN
    repeat (3) exp_q.push_back(DIR_LEFT);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (emit_cnt >= base + 3) break;
    end
    pen_down = 1'b0;
    sample_valid = 1'b0;
    check("t4_repeat_count", 32'(emit_cnt - base), 32'd3);
    if (hs_cyc.size() >= hs0 + 3) begin
      check("t4_first_gap", 32'(hs_cyc[hs0+1] - hs_cyc[hs0]), 32'(RF + 4));
      check("t4_rate_gap", 32'(hs_cyc[hs0+2] - hs_cyc[hs0+1]), 32'(RR + 4));
    end
`else
    exp_q.push_back(DIR_LEFT);
    tick(60);
    check("t4_single_emit", 32'(emit_cnt - base), 32'd1);
    pen_down = 1'b0;
    sample_valid = 1'b0;
`endif
    wait_idle("t4_idle");
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Battle mode frozen for the touch, single emit.
    battle_en = 1'b1; dir_in = DIR_DOWN; sample_valid = 1'b1;
    base = emit_cnt;
    exp_q.push_back(DIR_DOWN);
    pen_down = 1'b1;
    tick(12);
    check("t5_battle_on", 32'(battle_mode), 32'd1);
    battle_en = 1'b0;
    tick(40);
    check("t5_battle_frozen", 32'(battle_mode), 32'd1);
    check("t5_one_emit", 32'(emit_cnt - base), 32'd1);
    pen_down = 1'b0;
    sample_valid = 1'b0;
    wait_idle("t5_idle");
    check("t5_battle_until_idle", 32'(battle_mode), 32'd1);
    @(negedge clk);
    check("t5_battle_follows", 32'(battle_mode), 32'd0);

    // Multi-hot and zero decodes go to HOLD without emitting.
    base = emit_cnt;
    dir_in = 4'b0101;
    press_and_sample(8'd1, 8'd2);
    tick(1);
    @(negedge clk);
    check("t6_multihot_hold", 32'(dut.state_reg), 32'(ST_HOLD));
    check("t6_multihot_valid", 32'(dir_valid), 32'd0);
    pen_down = 1'b0;
    wait_idle("t6_idle_a");
    dir_in = 4'b0000;
    press_and_sample(8'd3, 8'd4);
    tick(1);
    @(negedge clk);
    check("t6_zero_hold", 32'(dut.state_reg), 32'(ST_HOLD));
    check("t6_zero_valid", 32'(dir_valid), 32'd0);
    pen_down = 1'b0;
    wait_idle("t6_idle_b");
    check("t6_no_emit", 32'(emit_cnt - base), 32'd0);

    // Reset asserted while a direction is being offered.
    battle_en = 1'b1; dir_ready = 1'b0; dir_in = DIR_RIGHT;
    press_and_sample(8'd9, 8'd8);
    wait_valid("t7_valid_rise");
    reset_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(dir_valid), 32'd0);
    check("t7_rst_dir_out", 32'(dir_out), 32'd0);
    check("t7_rst_x_hold", 32'(x_hold), 32'd0);
    check("t7_rst_y_hold", 32'(y_hold), 32'd0);
    check("t7_rst_battle", 32'(battle_mode), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    pen_down = 1'b0;
    dir_ready = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("t7_post_idle", 32'(busy), 32'd0);
    check("t7_no_emit", 32'(emit_cnt - base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
